// File: rtl/elevator_pkg.sv
// Shared call codes, controller state encoding and call-code decode for the elevator slice.
package elevator_pkg;

    localparam logic [2:0] CALL_NONE = 3'b000;
    localparam logic [2:0] CALL_1U   = 3'b001;
    localparam logic [2:0] CALL_2U   = 3'b010;
    localparam logic [2:0] CALL_3U   = 3'b011;
    localparam logic [2:0] CALL_4D   = 3'b100;
    localparam logic [2:0] CALL_2D   = 3'b110;
    localparam logic [2:0] CALL_3D   = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        MOVE,
        DOOR
    } state_t;

    // Floor 0 marks "no floor": NONE and the illegal 101 both decode to it.
    function automatic logic [2:0] code_to_floor(input logic [2:0] code);
        case (code)
            CALL_NONE:        return 3'd0;
            CALL_1U:          return 3'd1;
            CALL_2U, CALL_2D: return 3'd2;
            CALL_3U, CALL_3D: return 3'd3;
            CALL_4D:          return 3'd4;
            default:          return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by the travel and door phases of the elevator controller.
module elevator_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             dec,
    output logic             expired
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= value;
        end else if (dec && count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    // Flags the final count so the controller can act on the edge that ends the phase.
    assign expired = (count_reg == WIDTH'(1));

endmodule

// File: rtl/elevator_ctrl.sv
// Elevator car controller: pops one hall call, decodes its floor, moves the car and cycles the door.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4,
    parameter int RESET_FLOOR   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       q_empty,
    input  logic [2:0] req_code,
    output logic       done,
    output logic [2:0] floor,
    output logic       motor_up,
    output logic       motor_dn,
    output logic       door_open,
    output logic       call_dir,
    output logic       busy
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW = $clog2(MAX_CYCLES + 1);
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES);
    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES);

    state_t     state_reg, state_next;
    logic [2:0] floor_reg, floor_next;
    logic [2:0] target_reg, target_next;
    logic       dir_reg, dir_next;
    logic       call_dir_reg, call_dir_next;
    logic       done_reg, done_next;
    logic       motor_up_reg, motor_up_next;
    logic       motor_dn_reg, motor_dn_next;
    logic       door_open_reg, door_open_next;
    logic       busy_reg, busy_next;

    logic          timer_load;
    logic [TW-1:0] timer_value;
    logic          timer_dec;
    logic          timer_expired;
    logic [2:0]    code_floor;
    logic [2:0]    step_floor;

    elevator_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .value  (timer_value),
        .dec    (timer_dec),
        .expired(timer_expired)
    );

    assign code_floor = code_to_floor(req_code);
    // Saturating one-floor step keeps the car inside 1..4 whatever dir says.
    assign step_floor = dir_reg ? ((floor_reg == 3'd4) ? 3'd4 : floor_reg + 3'd1)
                                : ((floor_reg == 3'd1) ? 3'd1 : floor_reg - 3'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            floor_reg     <= 3'(RESET_FLOOR);
            target_reg    <= 3'(RESET_FLOOR);
            dir_reg       <= 1'b0;
            call_dir_reg  <= 1'b0;
            done_reg      <= 1'b0;
            motor_up_reg  <= 1'b0;
            motor_dn_reg  <= 1'b0;
            door_open_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            floor_reg     <= floor_next;
            target_reg    <= target_next;
            dir_reg       <= dir_next;
            call_dir_reg  <= call_dir_next;
            done_reg      <= done_next;
            motor_up_reg  <= motor_up_next;
            motor_dn_reg  <= motor_dn_next;
            door_open_reg <= door_open_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        floor_next    = floor_reg;
        target_next   = target_reg;
        dir_next      = dir_reg;
        call_dir_next = call_dir_reg;
        timer_load    = 1'b0;
        timer_value   = TRAVEL_LOAD;
        timer_dec     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!q_empty) state_next = FETCH;
            end
            FETCH: state_next = LATCH;
            LATCH: begin
                if (code_floor == 3'd0) begin
                    state_next = IDLE;
                end else begin
                    call_dir_next = req_code[2];
                    target_next   = code_floor;
                    timer_load    = 1'b1;
                    if (code_floor == floor_reg) begin
                        state_next  = DOOR;
                        timer_value = DOOR_LOAD;
                    end else begin
                        state_next = MOVE;
                        dir_next   = (code_floor > floor_reg);
                    end
                end
            end
            MOVE: begin
                timer_dec = 1'b1;
                if (timer_expired) begin
                    floor_next = step_floor;
                    timer_load = 1'b1;
                    if (step_floor == target_reg) begin
                        state_next  = DOOR;
                        timer_value = DOOR_LOAD;
                    end
                end
            end
            DOOR: begin
                timer_dec = 1'b1;
                if (timer_expired) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs follow the state being entered, so they change on the same edge as the state.
    always_comb begin
        done_next      = (state_next == FETCH);
        motor_up_next  = (state_next == MOVE) && dir_next;
        motor_dn_next  = (state_next == MOVE) && !dir_next;
        door_open_next = (state_next == DOOR);
        busy_next      = (state_next != IDLE);
    end

    assign done      = done_reg;
    assign floor     = floor_reg;
    assign motor_up  = motor_up_reg;
    assign motor_dn  = motor_dn_reg;
    assign door_open = door_open_reg;
    assign call_dir  = call_dir_reg;
    assign busy      = busy_reg;

endmodule
